sram_bus_responder: RTL

Bus-cycle responder for the 256 KB on-chip SRAM, the 68000-facing counterpart to the SRAM block-select decode. Given the four block selects from that decode and the 68000 strobes, it sequences the SRAM chip enables, output enable and byte write enables, inserts a programmable number of wait states, and returns registered read data and DTACK_L to the CPU. It sits between the top-level address decoder and the four 64 KB SRAM blocks.

---
 rtl/sram_resp_pkg.sv | 21 ++
 rtl/sram_bus_responder.sv | 109 ++++++++++
 2 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the 68000-facing SRAM bus-cycle responder.
// Holds the cycle state encoding, wait-state limits and the null-cycle read value.
package sram_resp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   localparam int WAIT_STATES_MIN = 1;
   localparam int WAIT_STATES_MAX = 15;

   localparam logic [15:0] IDLE_DATA_DEFAULT = 16'hFFFF;

   // Keep only the lowest set bit so overlapping block selects enable one block.
   function automatic logic [3:0] lowest_bit(input logic [3:0] sel);
      return sel & (~sel + 4'd1);
   endfunction

endpackage

// File: rtl/sram_bus_responder.sv
// Sequences CE/OE/WE for the four 64 KB SRAM blocks across a 68000 bus cycle,
// inserting WAIT_STATES clocks before latching read data and asserting DTACK_L.
module sram_bus_responder
   import sram_resp_pkg::*;
#(
   parameter int          WAIT_STATES = 2,
   parameter logic [15:0] IDLE_DATA   = IDLE_DATA_DEFAULT
) (
   input  logic        Clock,
   input  logic        Reset_L,
   input  logic        AS_L,
   input  logic        UDS_L,
   input  logic        LDS_L,
   input  logic        RW,
   input  logic        SRamSelect_H,
   input  logic [3:0]  Block_H,
   input  logic [15:0] RdData0,
   input  logic [15:0] RdData1,
   input  logic [15:0] RdData2,
   input  logic [15:0] RdData3,
   output logic [15:0] DataOut,
   output logic        DTACK_L,
   output logic [3:0]  SRamCE_L,
   output logic        SRamOE_L,
   output logic        SRamWE_U_L,
   output logic        SRamWE_L_L
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  blk_q;
   logic        rw_q;
   logic        uds_l_q;
   logic        lds_l_q;
   logic [15:0] data_q;
   logic [15:0] rd_sel;
   logic        start;
   logic        active;
   logic        we_win;

   assign start = !AS_L && SRamSelect_H;

   always_comb begin
      rd_sel = IDLE_DATA;
      if (blk_q[0])
         rd_sel = RdData0;
      else if (blk_q[1])
         rd_sel = RdData1;
      else if (blk_q[2])
         rd_sel = RdData2;
      else if (blk_q[3])
         rd_sel = RdData3;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACCESS;
         ACCESS: begin
            // Strobe withdrawal wins over completion: an aborted cycle never acknowledges.
            if (AS_L)
               state_d = IDLE;
            else if (cnt_q == WS)
               state_d = ACK;
         end
         ACK:     if (AS_L) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         blk_q   <= 4'd0;
         rw_q    <= 1'b1;
         uds_l_q <= 1'b1;
         lds_l_q <= 1'b1;
         data_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            blk_q   <= lowest_bit(Block_H);
            rw_q    <= RW;
            uds_l_q <= UDS_L;
            lds_l_q <= LDS_L;
            cnt_q   <= 4'd0;
         end
         if (state_q == ACCESS && state_d == ACCESS)
            cnt_q <= cnt_q + 4'd1;
         if (state_q == ACCESS && state_d == ACK && rw_q)
            data_q <= rd_sel;
      end
   end

   // Outputs come only from registered state; cnt>=1 gives one clock of address setup.
   assign active     = (state_q == ACCESS) || (state_q == ACK);
   assign we_win     = (state_q == ACCESS) && !rw_q && (cnt_q != 4'd0) && (blk_q != 4'd0);
   assign SRamCE_L   = active ? ~blk_q : 4'hF;
   assign SRamOE_L   = !(active && rw_q);
   assign SRamWE_U_L = !(we_win && !uds_l_q);
   assign SRamWE_L_L = !(we_win && !lds_l_q);
   assign DTACK_L    = (state_q != ACK);
   assign DataOut    = data_q;

endmodule
